mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle MIPS control FSM. Replaces the single-cycle opcode decoder when the CPU shares
//  one memory port and one ALU across instruction phases. Sequences the shared datapath
//  (PC, IR, register file, ALU, memory port) per instruction, with a ready handshake on memory.
//  Supports lw, sw, R-type, beq, bne, addi, ori, andi, j.
// PARAMETERS
//  MEM_TIMEOUT   16   max cycles waiting on mem_ready before err_timeout pulses (0 = disabled)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  op           in   6  IR[31:26], valid from DECODE onward
//  zero         in   1  ALU zero flag (branch compare)
//  mem_ready    in   1  memory port completes the current access this cycle
//  mem_req      out  1  memory access requested (FETCH, MEMRD, MEMWR)
//  memwrite     out  1  write strobe for the memory access
//  iord         out  1  0 = PC addresses memory, 1 = ALUOut
//  irwrite      out  1  load IR
//  pcen         out  1  PC write enable (pcwrite | branch taken)
//  regwrite     out  1  register file write
//  regdst       out  1  1 = rd, 0 = rt
//  memtoreg     out  1  1 = data register, 0 = ALUOut
//  alusrca      out  1  0 = PC, 1 = rs
//  alusrcb      out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//  pcsrc        out  2  00 ALU result, 01 ALUOut, 10 jump target
//  aluop        out  3  000 add, 001 sub, 010 funct, 011 or, 100 and
//  immext       out  1  1 = zero-extend imm (ori/andi), 0 = sign-extend
//  ill_op       out  1  one-cycle pulse: unsupported opcode in DECODE
//  err_timeout  out  1  one-cycle pulse: mem_ready not seen within MEM_TIMEOUT cycles
// BEHAVIOUR
//  - Reset (async): state = FETCH. Wait counter = 0. All outputs are combinational from state.
//    During reset every strobe (pcen, irwrite, regwrite, memwrite, mem_req) is 0.
//  - States are FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, ALUWB, BEQEX, BNEEX,
//    ADDIEX, ORIEX, ANDIEX, IMMWB, JEX.
//  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00.
//    irwrite and pcen are 1 only in the cycle mem_ready=1; then -> DECODE. Otherwise the FSM holds.
//  - DECODE: alusrca=0, alusrcb=11, aluop=000 (branch target to ALUOut). Next state by op:
//    100011/101011 -> MEMADR, 000000 -> RTEXE, 000100 -> BEQEX, 000101 -> BNEEX,
//    001000 -> ADDIEX, 001101 -> ORIEX, 001100 -> ANDIEX, 000010 -> JEX.
//    Any other op -> FETCH, with ill_op=1 for one cycle.
//  - MEMADR: alusrca=1, alusrcb=10, aluop=000. op=100011 -> MEMRD, else -> MEMWR.
//  - MEMRD: mem_req=1, iord=1. Holds until mem_ready, then -> MEMWB.
//  - MEMWB: regwrite=1, regdst=0, memtoreg=1 -> FETCH.
//  - MEMWR: mem_req=1, iord=1, memwrite=1. Holds until mem_ready, then -> FETCH.
//  - RTEXE: alusrca=1, alusrcb=00, aluop=010 -> ALUWB. ALUWB: regwrite=1, regdst=1 -> FETCH.
//  - BEQEX/BNEEX: alusrca=1, alusrcb=00, aluop=001, pcsrc=01.
//    pcen = zero (BEQ) or ~zero (BNE) -> FETCH.
//  - ADDIEX aluop=000 immext=0; ORIEX aluop=011 immext=1; ANDIEX aluop=100 immext=1.
//    All use alusrca=1, alusrcb=10 -> IMMWB. IMMWB: regwrite=1, regdst=0, memtoreg=0,
//    and holds the immext of the path it came from -> FETCH.
//  - JEX: pcsrc=10, pcen=1 -> FETCH.
//  - Wait counter: clears on entry to any mem state and increments each wait cycle.
//    On reaching MEM_TIMEOUT it pulses err_timeout and clears; the FSM keeps waiting (no abort).
//  - mem_ready is ignored outside mem states. An asserted mem_ready on entry completes the
//    access in 1 cycle (zero wait). Reset mid-access abandons it: no strobe is issued the next cycle.
//  - CPI with zero waits: lw 5, sw 4, R/imm 4, branch/j 3.
// CONFIGURATION
//  MC_PERF_CNT_EN defined:
//    adds output instret [31:0] (instructions completed) and output cycles [31:0].
//    Both reset to 0 and wrap modulo 2^32.
//    instret increments on every transition into FETCH from a non-FETCH state,
//    except the transition after ill_op. cycles increments every cycle when not in reset.
//  Not defined: ports are absent and no counter logic exists.
// STRUCTURE
//  Package mc_pkg holds: state_t enum, opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
//  OP_BNE, OP_ADDI, OP_ORI, OP_ANDI, OP_J), aluop_t encodings, and alusrcb/pcsrc encodings.
//  One sub-module: mc_outdec (combinational state -> control word). The FSM register,
//  next-state logic and wait counter stay in the top.
// TESTING
//  1. reset=1 mid-MEMRD with mem_ready=0 -> next cycle state=FETCH, all strobes 0, mem_req=1
//     after release.
//  2. lw (op=100011), mem_ready tied 1 -> irwrite@c0, regwrite & memtoreg@c4, FETCH@c5.
//  3. FETCH with mem_ready low for 3 cycles -> irwrite/pcen stay 0, pulse on cycle 4 only.
//  4. beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX. bne with zero=1 -> pcen=0.
//  5. ori (op=001101) -> ORIEX aluop=011 immext=1. IMMWB regwrite=1 regdst=0.
//     op=111111 -> ill_op pulse, back to FETCH.
//  6. MEM_TIMEOUT=4, mem_ready held 0 in MEMWR -> err_timeout pulses after 4 wait cycles,
//     memwrite stays 1. With MC_PERF_CNT_EN, 3 completed instrs -> instret=3.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: FSM states,
// opcodes, ALU operation codes and the datapath mux selects.
package mc_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      RTEXE  = 4'd6,
      ALUWB  = 4'd7,
      BEQEX  = 4'd8,
      BNEEX  = 4'd9,
      ADDIEX = 4'd10,
      ORIEX  = 4'd11,
      ANDIEX = 4'd12,
      IMMWB  = 4'd13,
      JEX    = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_FUNCT = 3'b010,
      ALU_OR    = 3'b011,
      ALU_AND   = 3'b100
   } aluop_t;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   function automatic logic op_known(input logic [5:0] op);
      return (op == OP_LW)   || (op == OP_SW)   || (op == OP_RTYPE) ||
             (op == OP_BEQ)  || (op == OP_BNE)  || (op == OP_ADDI)  ||
             (op == OP_ORI)  || (op == OP_ANDI) || (op == OP_J);
   endfunction

   // Logical immediates are zero-extended; everything else sign-extends.
   function automatic logic op_zero_ext(input logic [5:0] op);
      return (op == OP_ORI) || (op == OP_ANDI);
   endfunction

   function automatic logic is_mem_state(input state_t s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/mc_outdec.sv
// Control-word decoder: maps the current FSM state (plus zero / mem_ready for the
// conditional strobes) onto the shared-datapath control signals.
module mc_outdec
   import mc_pkg::*;
(
   input  logic [3:0] state,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       iord,
   output logic       irwrite,
   output logic       pcen,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] aluop,
   output logic       immext,
   output logic       ill_op
);

   state_t st;
   assign st = state_t'(state);

   always_comb begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = SRCB_RT;
      pcsrc    = PC_ALU;
      aluop    = ALU_ADD;
      immext   = 1'b0;
      ill_op   = 1'b0;
      case (st)
         FETCH: begin
            mem_req = 1'b1;
            alusrcb = SRCB_FOUR;
            irwrite = mem_ready;
            pcen    = mem_ready;
         end
         DECODE: begin
            alusrcb = SRCB_IMMSH;
            ill_op  = ~op_known(op);
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         RTEXE: begin
            alusrca = 1'b1;
            aluop   = ALU_FUNCT;
         end
         ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         BEQEX, BNEEX: begin
            alusrca = 1'b1;
            aluop   = ALU_SUB;
            pcsrc   = PC_ALUOUT;
            pcen    = (st == BEQEX) ? zero : ~zero;
         end
         ADDIEX, ORIEX, ANDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluop   = (st == ORIEX)  ? ALU_OR  :
                      (st == ANDIEX) ? ALU_AND : ALU_ADD;
            immext  = (st != ADDIEX);
         end
         // IR is still held, so the opcode tells which immediate path we came from.
         IMMWB: begin
            regwrite = 1'b1;
            immext   = op_zero_ext(op);
         end
         JEX: begin
            pcsrc = PC_JUMP;
            pcen  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory ready handshake and wait timeout.
// Optional MC_PERF_CNT_EN adds instret/cycles performance counters.
module mips_multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  op,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        memwrite,
   output logic        iord,
   output logic        irwrite,
   output logic        pcen,
   output logic        regwrite,
   output logic        regdst,
   output logic        memtoreg,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic [1:0]  pcsrc,
   output logic [2:0]  aluop,
   output logic        immext,
   output logic        ill_op,
   output logic        err_timeout
`ifdef MC_PERF_CNT_EN
  ,output logic [31:0] instret
  ,output logic [31:0] cycles
`endif
);

   state_t state, state_nxt;
   logic   mem_req_raw, memwrite_raw, irwrite_raw, pcen_raw, regwrite_raw, ill_raw;
   logic   waiting, to_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:  if (mem_ready) state_nxt = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_RTYPE:     state_nxt = RTEXE;
               OP_BEQ:       state_nxt = BEQEX;
               OP_BNE:       state_nxt = BNEEX;
               OP_ADDI:      state_nxt = ADDIEX;
               OP_ORI:       state_nxt = ORIEX;
               OP_ANDI:      state_nxt = ANDIEX;
               OP_J:         state_nxt = JEX;
               default:      state_nxt = FETCH;
            endcase
         end
         MEMADR: state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  if (mem_ready) state_nxt = MEMWB;
         MEMWR:  if (mem_ready) state_nxt = FETCH;
         RTEXE:  state_nxt = ALUWB;
         ADDIEX, ORIEX, ANDIEX: state_nxt = IMMWB;
         MEMWB, ALUWB, BEQEX, BNEEX, IMMWB, JEX: state_nxt = FETCH;
         default: state_nxt = FETCH;
      endcase
   end

   assign waiting = is_mem_state(state) && !mem_ready;

   // Timeout only reports; the FSM keeps waiting on the access.
   generate
      if (MEM_TIMEOUT > 0) begin : g_timeout
         localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
         logic [CW-1:0] wait_cnt;

         assign to_hit = waiting && (wait_cnt == CW'(MEM_TIMEOUT - 1));

         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               wait_cnt <= '0;
            else if ((state_nxt != state) || !waiting || to_hit)
               wait_cnt <= '0;
            else
               wait_cnt <= wait_cnt + CW'(1);
         end
      end else begin : g_no_timeout
         assign to_hit = 1'b0;
      end
   endgenerate

   mc_outdec u_outdec (
      .state     (state),
      .op        (op),
      .zero      (zero),
      .mem_ready (mem_ready),
      .mem_req   (mem_req_raw),
      .memwrite  (memwrite_raw),
      .iord      (iord),
      .irwrite   (irwrite_raw),
      .pcen      (pcen_raw),
      .regwrite  (regwrite_raw),
      .regdst    (regdst),
      .memtoreg  (memtoreg),
      .alusrca   (alusrca),
      .alusrcb   (alusrcb),
      .pcsrc     (pcsrc),
      .aluop     (aluop),
      .immext    (immext),
      .ill_op    (ill_raw)
   );

   // Strobes are masked while reset is held so an abandoned access issues nothing.
   assign mem_req     = mem_req_raw  & ~reset;
   assign memwrite    = memwrite_raw & ~reset;
   assign irwrite     = irwrite_raw  & ~reset;
   assign pcen        = pcen_raw     & ~reset;
   assign regwrite    = regwrite_raw & ~reset;
   assign ill_op      = ill_raw      & ~reset;
   assign err_timeout = to_hit       & ~reset;

`ifdef MC_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret <= 32'd0;
         cycles  <= 32'd0;
      end else begin
         cycles <= cycles + 32'd1;
         if ((state != FETCH) && (state_nxt == FETCH) && !ill_raw)
            instret <= instret + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl (built with MEM_TIMEOUT=4).
module tb_mips_multicycle_ctrl;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                          BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                          ORI = 6'b001101, ANDI = 6'b001100, JMP = 6'b000010,
                          BAD1 = 6'b111111, BAD2 = 6'b000001;

   // {mem_req,memwrite,iord,irwrite,pcen}_{regwrite,regdst,memtoreg}_alusrca_
   // alusrcb_pcsrc_aluop_{immext,ill_op,err_timeout}
   localparam logic [18:0]
      X_RESET    = 19'b00000_000_0_01_00_000_000,
      X_FETCH_GO = 19'b10011_000_0_01_00_000_000,
      X_FETCH_WT = 19'b10000_000_0_01_00_000_000,
      X_DECODE   = 19'b00000_000_0_11_00_000_000,
      X_DEC_ILL  = 19'b00000_000_0_11_00_000_010,
      X_MEMADR   = 19'b00000_000_1_10_00_000_000,
      X_MEMRD    = 19'b10100_000_0_00_00_000_000,
      X_MEMWB    = 19'b00000_101_0_00_00_000_000,
      X_MEMWR    = 19'b11100_000_0_00_00_000_000,
      X_MEMWR_TO = 19'b11100_000_0_00_00_000_001,
      X_RTEXE    = 19'b00000_000_1_00_00_010_000,
      X_ALUWB    = 19'b00000_110_0_00_00_000_000,
      X_BR_TK    = 19'b00001_000_1_00_01_001_000,
      X_BR_NT    = 19'b00000_000_1_00_01_001_000,
      X_ADDIEX   = 19'b00000_000_1_10_00_000_000,
      X_ORIEX    = 19'b00000_000_1_10_00_011_100,
      X_ANDIEX   = 19'b00000_000_1_10_00_100_100,
      X_IMMWB_Z  = 19'b00000_100_0_00_00_000_100,
      X_IMMWB_S  = 19'b00000_100_0_00_00_000_000,
      X_JEX      = 19'b00001_000_0_00_10_000_000;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic        zero;
      logic        rdy;
      logic [18:0] exp;
      bit          done;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  op;
   logic        zero, mem_ready;
   logic        mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg;
   logic        alusrca, immext, ill_op, err_timeout;
   logic [1:0]  alusrcb, pcsrc;
   logic [2:0]  aluop;
`ifdef MC_PERF_CNT_EN
   logic [31:0] instret, cycles;
`endif

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
      .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
      .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
      .immext(immext), .ill_op(ill_op), .err_timeout(err_timeout)
`ifdef MC_PERF_CNT_EN
     ,.instret(instret), .cycles(cycles)
`endif
   );

   function automatic logic [18:0] outs();
      return {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
              alusrca, alusrcb, pcsrc, aluop, immext, ill_op, err_timeout};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add(input string n, input logic [5:0] o, input logic z, input logic r,
                      input logic [18:0] e, input bit d);
      vec_t v;
      v.name = n; v.op = o; v.zero = z; v.rdy = r; v.exp = e; v.done = d;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ndone = 0;

      // lw, zero wait (mem_ready tied high)
      add("lw_fetch", LW, 0, 1, X_FETCH_GO, 0);
      add("lw_decode", LW, 0, 1, X_DECODE, 0);
      add("lw_memadr", LW, 0, 1, X_MEMADR, 0);
      add("lw_memrd", LW, 0, 1, X_MEMRD, 0);
      add("lw_memwb", LW, 0, 1, X_MEMWB, 1);
      add("sw_fetch", SW, 0, 1, X_FETCH_GO, 0);
      add("sw_decode", SW, 0, 1, X_DECODE, 0);
      add("sw_memadr", SW, 0, 1, X_MEMADR, 0);
      add("sw_memwr", SW, 0, 1, X_MEMWR, 1);
      add("r_fetch", RT, 1, 1, X_FETCH_GO, 0);
      add("r_decode", RT, 1, 1, X_DECODE, 0);
      add("r_exe", RT, 1, 1, X_RTEXE, 0);
      add("r_wb", RT, 1, 1, X_ALUWB, 1);
      add("beq1_fetch", BEQ, 0, 1, X_FETCH_GO, 0);
      add("beq1_decode", BEQ, 0, 1, X_DECODE, 0);
      add("beq_z1", BEQ, 1, 1, X_BR_TK, 1);
      add("beq0_fetch", BEQ, 0, 1, X_FETCH_GO, 0);
      add("beq0_decode", BEQ, 0, 0, X_DECODE, 0);
      add("beq_z0", BEQ, 0, 0, X_BR_NT, 1);
      add("bne1_fetch", BNE, 0, 1, X_FETCH_GO, 0);
      add("bne1_decode", BNE, 0, 1, X_DECODE, 0);
      add("bne_z1", BNE, 1, 1, X_BR_NT, 1);
      add("bne0_fetch", BNE, 0, 1, X_FETCH_GO, 0);
      add("bne0_decode", BNE, 0, 1, X_DECODE, 0);
      add("bne_z0", BNE, 0, 1, X_BR_TK, 1);
      add("addi_fetch", ADDI, 0, 1, X_FETCH_GO, 0);
      add("addi_decode", ADDI, 0, 1, X_DECODE, 0);
      add("addi_ex", ADDI, 0, 1, X_ADDIEX, 0);
      add("addi_wb", ADDI, 0, 1, X_IMMWB_S, 1);
      add("ori_fetch", ORI, 0, 1, X_FETCH_GO, 0);
      add("ori_decode", ORI, 0, 1, X_DECODE, 0);
      add("ori_ex", ORI, 0, 1, X_ORIEX, 0);
      add("ori_wb", ORI, 0, 1, X_IMMWB_Z, 1);
      add("andi_fetch", ANDI, 0, 1, X_FETCH_GO, 0);
      add("andi_decode", ANDI, 0, 1, X_DECODE, 0);
      add("andi_ex", ANDI, 0, 1, X_ANDIEX, 0);
      add("andi_wb", ANDI, 0, 1, X_IMMWB_Z, 1);
      add("j_fetch", JMP, 0, 1, X_FETCH_GO, 0);
      add("j_decode", JMP, 0, 1, X_DECODE, 0);
      add("j_ex", JMP, 0, 1, X_JEX, 1);
      add("ill1_fetch", BAD1, 0, 1, X_FETCH_GO, 0);
      add("ill1_decode", BAD1, 0, 1, X_DEC_ILL, 0);
      add("ill2_fetch", BAD2, 0, 1, X_FETCH_GO, 0);
      add("ill2_decode", BAD2, 0, 1, X_DEC_ILL, 0);
      // lw with FETCH and MEMRD wait states
      add("lww_fetch_w1", LW, 0, 0, X_FETCH_WT, 0);
      add("lww_fetch_w2", LW, 0, 0, X_FETCH_WT, 0);
      add("lww_fetch_w3", LW, 0, 0, X_FETCH_WT, 0);
      add("lww_fetch_go", LW, 0, 1, X_FETCH_GO, 0);
      add("lww_decode", LW, 0, 0, X_DECODE, 0);
      add("lww_memadr", LW, 0, 0, X_MEMADR, 0);
      add("lww_memrd_w1", LW, 0, 0, X_MEMRD, 0);
      add("lww_memrd_w2", LW, 0, 0, X_MEMRD, 0);
      add("lww_memrd_go", LW, 0, 1, X_MEMRD, 0);
      add("lww_memwb", LW, 0, 0, X_MEMWB, 1);
      // sw stalled past the timeout twice
      add("swt_fetch", SW, 0, 1, X_FETCH_GO, 0);
      add("swt_decode", SW, 0, 1, X_DECODE, 0);
      add("swt_memadr", SW, 0, 1, X_MEMADR, 0);
      add("swt_w1", SW, 0, 0, X_MEMWR, 0);
      add("swt_w2", SW, 0, 0, X_MEMWR, 0);
      add("swt_w3", SW, 0, 0, X_MEMWR, 0);
      add("swt_w4_to", SW, 0, 0, X_MEMWR_TO, 0);
      add("swt_w5", SW, 0, 0, X_MEMWR, 0);
      add("swt_w6", SW, 0, 0, X_MEMWR, 0);
      add("swt_w7", SW, 0, 0, X_MEMWR, 0);
      add("swt_w8_to", SW, 0, 0, X_MEMWR_TO, 0);
      add("swt_done", SW, 0, 1, X_MEMWR, 1);

      // reset state: strobes masked even with mem_ready high
      reset = 1'b1; op = LW; zero = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs", 32'(outs()), 32'(X_RESET));
      @(posedge clk); #1;
      reset = 1'b0;

      foreach (tbl[i]) begin
         op = tbl[i].op; zero = tbl[i].zero; mem_ready = tbl[i].rdy;
         @(negedge clk);
         chk(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
         if (tbl[i].done) ndone++;
         @(posedge clk); #1;
      end

      // reset mid-MEMRD with mem_ready low
      op = LW; zero = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      chk("rst_seq_fetch", 32'(outs()), 32'(X_FETCH_GO));
`ifdef MC_PERF_CNT_EN
      chk("perf_instret", instret, 32'(ndone));
      chk("perf_cycles", cycles, 32'(tbl.size()));
`endif
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_seq_decode", 32'(outs()), 32'(X_DECODE));
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_seq_memadr", 32'(outs()), 32'(X_MEMADR));
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("rst_seq_memrd", 32'(outs()), 32'(X_MEMRD));
      #2 reset = 1'b1;
      #1 chk("rst_async_outputs", 32'(outs()), 32'(X_RESET));
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("rst_held_fetch", 32'(outs()), 32'(X_RESET));
      @(posedge clk); #1;
      reset = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("rst_release_fetch", 32'(outs()), 32'(X_FETCH_WT));
`ifdef MC_PERF_CNT_EN
      chk("perf_instret_rst", instret, 32'd0);
      chk("perf_cycles_rst", cycles, 32'd0);
`endif
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(negedge clk);
      chk("rst_release_go", 32'(outs()), 32'(X_FETCH_GO));
`ifdef MC_PERF_CNT_EN
      chk("perf_cycles_one", cycles, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
